// File: rtl/fpga_array_pkg.sv
// fpga_array_pkg: shared types and helpers for the LUT fabric.
//   state_e        - load/run controller states
//   SEL_*          - per-input select encodings of a LUT cell
//   cell_cfg_bits  - configuration bits per cell for a given LUT size
package fpga_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_PIN  = 2'd0;
  localparam logic [1:0] SEL_PREV = 2'd1;
  localparam logic [1:0] SEL_ZERO = 2'd2;
  localparam logic [1:0] SEL_ONE  = 2'd3;

  // truth table + 2-bit select per input + reg_en
  function automatic int cell_cfg_bits(input int k);
    return (2 ** k) + 2 * k + 1;
  endfunction

endpackage

// File: rtl/fpga_lut_cell.sv
// fpga_lut_cell: one fabric cell - LUT_K-input LUT, input select muxes and
// an optional output flip-flop.
//   clk, reset - clock, synchronous active-high reset
//   run        - fabric is configured; when low the output and FF are 0
//   cfg        - {reg_en, sel[K-1..0], truth_table}
//   pins       - this cell's external inputs
//   prev_in    - final output of the previous cell (0 for cell 0)
//   out        - cell output (combinational or registered)
module fpga_lut_cell
  import fpga_array_pkg::*;
#(
  parameter  int LUT_K    = 4,
  localparam int CELL_CFG = cell_cfg_bits(LUT_K),
  localparam int TT_BITS  = 2 ** LUT_K
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [CELL_CFG-1:0] cfg,
  input  logic [LUT_K-1:0]    pins,
  input  logic                prev_in,
  output logic                out
);

  logic [TT_BITS-1:0] tt;
  logic [LUT_K-1:0]   lut_in;
  logic               lut_out;
  logic               reg_en;
  logic               ff_q;

  assign tt     = cfg[TT_BITS-1:0];
  assign reg_en = cfg[CELL_CFG-1];

  always_comb begin
    lut_in = '0;
    for (int i = 0; i < LUT_K; i++) begin
      case (cfg[TT_BITS+2*i +: 2])
        SEL_PIN:  lut_in[i] = pins[i];
        SEL_PREV: lut_in[i] = prev_in;
        SEL_ZERO: lut_in[i] = 1'b0;
        default:  lut_in[i] = 1'b1;
      endcase
    end
  end

  assign lut_out = tt[lut_in];

  // FF is held clear outside RUN so a fresh configuration starts from 0
  always_ff @(posedge clk) begin
    if (reset || !run) ff_q <= 1'b0;
    else               ff_q <= lut_out;
  end

  assign out = run & (reg_en ? ff_q : lut_out);

endmodule

// File: rtl/fpga_array.sv
// fpga_array: 1-D chain of NUM_CELLS LUT cells configured through a serial
// shift chain under a small IDLE/LOAD/RUN controller.
//   clk, reset          - clock, synchronous active-high reset
//   cfg_start           - pulse: (re)enter LOAD, clear bit counter
//   cfg_valid, cfg_data - serial config bit and its qualifier
//   cfg_ready           - high in LOAD
//   cfg_done            - high in RUN
//   cfg_count           - bits accepted in the current load
//   cell_in             - cell c uses bits [c*LUT_K +: LUT_K]
//   cell_out            - bit c is the output of cell c
module fpga_array
  import fpga_array_pkg::*;
#(
  parameter  int NUM_CELLS = 4,
  parameter  int LUT_K     = 4,
  localparam int CELL_CFG  = cell_cfg_bits(LUT_K),
  localparam int CFG_BITS  = NUM_CELLS * CELL_CFG,
  localparam int CNT_W     = $clog2(CFG_BITS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic                       cfg_data,
  output logic                       cfg_ready,
  output logic                       cfg_done,
  output logic [CNT_W-1:0]           cfg_count,
  input  logic [NUM_CELLS*LUT_K-1:0] cell_in,
  output logic [NUM_CELLS-1:0]       cell_out
);

  state_e                state_q;
  logic [CFG_BITS-1:0]   chain_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ready_q;
  logic                  done_q;

  logic [NUM_CELLS-1:0][CELL_CFG-1:0] cell_cfg;
  logic [NUM_CELLS-1:0][LUT_K-1:0]    pins;

  // Controller, counter and chain. cfg_start takes priority over everything,
  // so a valid bit on the same cycle is dropped. The chain is not cleared on
  // restart; RUN is only reachable after a full CFG_BITS reload anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      chain_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (cfg_start) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (cfg_valid) begin
            chain_q <= {cfg_data, chain_q[CFG_BITS-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
              state_q <= RUN;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign cfg_count = cnt_q;

  assign cell_cfg = chain_q;
  assign pins     = cell_in;

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    logic prev;
    if (c == 0) begin : g_first
      assign prev = 1'b0;
    end else begin : g_rest
      assign prev = cell_out[c-1];
    end

    fpga_lut_cell #(.LUT_K(LUT_K)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .run     (done_q),
      .cfg     (cell_cfg[c]),
      .pins    (pins[c]),
      .prev_in (prev),
      .out     (cell_out[c])
    );
  end

endmodule

// File: tb/tb_fpga_array.sv
module tb_fpga_array;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int TT = 2 ** K;
  localparam int CC = TT + 2 * K + 1;
  localparam int CB = N * CC;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_start = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_data = 1'b0;
  logic             cfg_ready;
  logic             cfg_done;
  logic [6:0]       cfg_count;
  logic [N*K-1:0]   cell_in = '0;
  logic [N-1:0]     cell_out;

  int n_chk  = 0;
  int n_fail = 0;
  bit do_chk = 0;

  fpga_array #(.NUM_CELLS(N), .LUT_K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_count (cfg_count),
    .cell_in   (cell_in),
    .cell_out  (cell_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // mode: 0 idle, 1 loading, 2 running. Configuration is the list of bits
  // accepted in the last complete load, bit j of the list = config bit j.
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_q[$];
  bit m_cfg[CB];
  bit m_ff[N];

  function automatic void m_eval(output logic [N-1:0] outv, output logic [N-1:0] lutv);
    bit prev, v, lut, o;
    int base, idx, sel;
    prev = 0;
    outv = '0;
    lutv = '0;
    for (int c = 0; c < N; c++) begin
      base = c * CC;
      idx  = 0;
      for (int i = 0; i < K; i++) begin
        sel = int'(m_cfg[base+TT+2*i]) + 2 * int'(m_cfg[base+TT+2*i+1]);
        case (sel)
          0:       v = cell_in[c*K+i];
          1:       v = prev;
          2:       v = 0;
          default: v = 1;
        endcase
        if (v) idx += (1 << i);
      end
      lut = m_cfg[base+idx];
      o   = m_cfg[base+CC-1] ? m_ff[c] : lut;
      if (m_mode != 2) o = 0;
      outv[c] = o;
      lutv[c] = lut;
      prev    = o;
    end
  endfunction

  task automatic m_step();
    logic [N-1:0] o, l;
    m_eval(o, l);
    if (reset) begin
      m_mode = 0;
      m_cnt  = 0;
      m_q.delete();
      foreach (m_ff[c])  m_ff[c]  = 0;
      foreach (m_cfg[j]) m_cfg[j] = 0;
    end else begin
      for (int c = 0; c < N; c++) m_ff[c] = (m_mode == 2) ? l[c] : 1'b0;
      if (cfg_start) begin
        m_mode = 1;
        m_cnt  = 0;
        m_q.delete();
      end else if (m_mode == 1 && cfg_valid) begin
        m_q.push_back(cfg_data);
        m_cnt++;
        if (m_cnt == CB) begin
          m_mode = 2;
          for (int j = 0; j < CB; j++) m_cfg[j] = m_q[j];
        end
      end
    end
  endtask

  // one clock: drive, compare against model before the edge, advance model
  task automatic cyc(input logic st, input logic vl, input logic dt, input logic rs = 1'b0);
    logic [N-1:0] o, l;
    cfg_start = st;
    cfg_valid = vl;
    cfg_data  = dt;
    reset     = rs;
    #1;
    if (do_chk) begin
      m_eval(o, l);
      check("cfg_ready", 32'(cfg_ready), 32'(m_mode == 1));
      check("cfg_done",  32'(cfg_done),  32'(m_mode == 2));
      check("cfg_count", 32'(cfg_count), 32'(m_cnt));
      check("cell_out",  32'(cell_out),  32'(o));
    end
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  function automatic logic [CC-1:0] mk_cell(input logic [TT-1:0] tt,
                                            input logic [2*K-1:0] sels,
                                            input logic ren);
    return {ren, sels, tt};
  endfunction

  // gap: 0 none, 1 random idles, 2 fixed valid,idle,idle pattern
  task automatic load(input logic [CB-1:0] v, input int gap);
    cyc(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < CB; j++) begin
      if (gap == 1)
        while ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      cyc(1'b0, 1'b1, v[j]);
      if (gap == 2) begin
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  logic [CB-1:0] vec;
  logic [N-1:0]  exp_pipe;

  initial begin
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    do_chk = 1;

    // 1: reset state, idle, valid without start is ignored
    check("rst_ready", 32'(cfg_ready), 0);
    check("rst_done",  32'(cfg_done),  0);
    check("rst_count", 32'(cfg_count), 0);
    check("rst_out",   32'(cell_out),  0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    check("idle_count", 32'(cfg_count), 0);
    check("idle_ready", 32'(cfg_ready), 0);

    // 2: cell0 4-input AND, combinational
    vec = '0;
    vec[0 +: CC] = mk_cell(16'h8000, 8'h00, 1'b0);
    load(vec, 0);
    check("t2_done", 32'(cfg_done), 1);
    check("t2_cnt",  32'(cfg_count), CB);
    cell_in = 16'h000F; #1;
    check("t2_and1", 32'(cell_out[0]), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cell_in = 16'h000E; #1;
    check("t2_and0", 32'(cell_out[0]), 0);
    cyc(1'b0, 1'b0, 1'b0);

    // 3: registered chain, one stage per clock
    cell_in = '0;
    vec[0*CC +: CC] = mk_cell(16'hAAAA, 8'h00, 1'b1);
    vec[1*CC +: CC] = mk_cell(16'hAAAA, 8'h01, 1'b1);
    vec[2*CC +: CC] = mk_cell(16'hAAAA, 8'h01, 1'b1);
    vec[3*CC +: CC] = mk_cell(16'hAAAA, 8'h01, 1'b1);
    load(vec, 1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    cell_in = 16'h0001;
    exp_pipe = '0;
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      exp_pipe = {exp_pipe[N-2:0], 1'b1};
      check("t3_pipe", 32'(cell_out), 32'(exp_pipe));
    end

    // 4: valid 1,0,0 pattern
    cell_in = 16'($urandom);
    for (int j = 0; j < CB; j++) vec[j] = 1'($urandom);
    load(vec, 2);
    check("t4_done", 32'(cfg_done), 1);
    check("t4_cnt",  32'(cfg_count), CB);
    repeat (10) begin
      cell_in = 16'($urandom);
      cyc(1'b0, 1'b0, 1'b0);
    end

    // 5: restart mid-load with a simultaneous valid
    cyc(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 50; j++) cyc(1'b0, 1'b1, 1'($urandom));
    check("t5_cnt50", 32'(cfg_count), 50);
    cyc(1'b1, 1'b1, 1'b1);
    check("t5_cnt0", 32'(cfg_count), 0);
    check("t5_out0", 32'(cell_out), 0);
    for (int j = 0; j < CB - 1; j++) cyc(1'b0, 1'b1, vec[j]);
    check("t5_notdone", 32'(cfg_done), 0);
    cyc(1'b0, 1'b1, vec[CB-1]);
    check("t5_done", 32'(cfg_done), 1);
    repeat (10) begin
      cell_in = 16'($urandom);
      cyc(1'b0, 1'b0, 1'b0);
    end

    // 6: constant-1 select, then reset and an all-zero load
    vec = '0;
    vec[0 +: CC] = mk_cell(16'h8000, 8'hC0, 1'b0);
    cell_in = '0;
    load(vec, 0);
    cell_in = 16'h0007; #1;
    check("t6_one", 32'(cell_out[0]), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_out",  32'(cell_out),  0);
    check("t6_rst_done", 32'(cfg_done),  0);
    check("t6_rst_cnt",  32'(cfg_count), 0);
    check("t6_rst_rdy",  32'(cfg_ready), 0);
    load('0, 0);
    for (int j = 0; j < 8; j++) begin
      cell_in = 16'($urandom);
      cyc(1'b0, 1'b0, 1'b0);
      check("t6_zero", 32'(cell_out), 0);
    end

    // random configurations, gaps and pin traffic
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < CB; j++) vec[j] = 1'($urandom);
      load(vec, 1);
      repeat (30) begin
        cell_in = 16'($urandom);
        cyc(1'b0, 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
